bus_arbiter_mem: RTL and testbench

- Responder end of the single-bus protocol driven by two cache controllers.
- Captures each controller's one-cycle bus_access request and arbitrates round-robin between them.
- Services one request at a time against an internal 256x8 main memory with fixed latency.
- Returns a one-cycle finish pulse and read data to the requester. On every completed write, broadcasts a snoop-invalidate (flag_snoop plus snoop_address) to the other controller.

---
 rtl/bus_arbiter_mem_if.sv | 38 +++
 rtl/bus_arbiter_mem.sv | 131 +++++++++++++
 tb/tb_bus_arbiter_mem.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_mem_if.sv
// Request/response signal bundle between the two cache controllers and the bus arbiter.
// master = controller side, slave = arbiter/memory side.
interface bus_arbiter_mem_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              bus_access0;
  logic              write_opn0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              bus_access1;
  logic              write_opn1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;

  logic              finish0;
  logic              finish1;
  logic [DATA_W-1:0] out_data_Mem;
  logic              flag_snoop0;
  logic [ADDR_W-1:0] snoop_address0;
  logic              flag_snoop1;
  logic [ADDR_W-1:0] snoop_address1;
  logic              bus_busy;

  modport master (
    output bus_access0, write_opn0, addr0, wdata0,
    output bus_access1, write_opn1, addr1, wdata1,
    input  finish0, finish1, out_data_Mem,
    input  flag_snoop0, snoop_address0, flag_snoop1, snoop_address1, bus_busy
  );

  modport slave (
    input  bus_access0, write_opn0, addr0, wdata0,
    input  bus_access1, write_opn1, addr1, wdata1,
    output finish0, finish1, out_data_Mem,
    output flag_snoop0, snoop_address0, flag_snoop1, snoop_address1, bus_busy
  );
endinterface

// File: rtl/bus_arbiter_mem.sv
// Round-robin arbiter for two cache controllers in front of a fixed-latency main memory,
// with a snoop-invalidate broadcast to the other controller on every completed write.
//
// state | meaning
// IDLE  | no transaction in flight; grants a pending requester on this edge
// BUSY  | granted transaction counting down; completes when cnt reaches 0
module bus_arbiter_mem #(
  parameter int MEM_LATENCY = 2,
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8
) (
  input logic               CC_clk,
  input logic               rst,
  bus_arbiter_mem_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = 4;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        pending;
  logic [1:0]        slot_wr;
  logic [ADDR_W-1:0] slot_addr [2];
  logic [DATA_W-1:0] slot_data [2];
  logic              last_grant;
  logic              grant;
  logic              cur_wr;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_data;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [1:0]        req_v;
  logic [1:0]        req_wr;
  logic [ADDR_W-1:0] req_addr [2];
  logic [DATA_W-1:0] req_data [2];
  logic              sel;

  always_comb begin
    req_v       = {bus.bus_access1, bus.bus_access0};
    req_wr      = {bus.write_opn1, bus.write_opn0};
    req_addr[0] = bus.addr0;
    req_addr[1] = bus.addr1;
    req_data[0] = bus.wdata0;
    req_data[1] = bus.wdata1;
    // On a tie the requester that did not win last time goes next.
    sel = (pending == 2'b11) ? ~last_grant : pending[1];
  end

  always_ff @(posedge CC_clk) begin
    if (rst) begin
      state              <= IDLE;
      cnt                <= '0;
      pending            <= '0;
      slot_wr            <= '0;
      slot_addr[0]       <= '0;
      slot_addr[1]       <= '0;
      slot_data[0]       <= '0;
      slot_data[1]       <= '0;
      last_grant         <= 1'b1;
      grant              <= 1'b0;
      cur_wr             <= 1'b0;
      cur_addr           <= '0;
      cur_data           <= '0;
      bus.finish0        <= 1'b0;
      bus.finish1        <= 1'b0;
      bus.out_data_Mem   <= '0;
      bus.flag_snoop0    <= 1'b0;
      bus.snoop_address0 <= '0;
      bus.flag_snoop1    <= 1'b0;
      bus.snoop_address1 <= '0;
      bus.bus_busy       <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      bus.finish0     <= 1'b0;
      bus.finish1     <= 1'b0;
      bus.flag_snoop0 <= 1'b0;
      bus.flag_snoop1 <= 1'b0;

      for (int i = 0; i < 2; i++) begin
        if (req_v[i] && !pending[i]) begin
          pending[i]   <= 1'b1;
          slot_wr[i]   <= req_wr[i];
          slot_addr[i] <= req_addr[i];
          slot_data[i] <= req_data[i];
        end
      end

      case (state)
        IDLE: begin
          if (|pending) begin
            grant        <= sel;
            last_grant   <= sel;
            pending[sel] <= 1'b0;
            // Slot is copied so a new request from the same controller can be queued during BUSY.
            cur_wr       <= slot_wr[sel];
            cur_addr     <= slot_addr[sel];
            cur_data     <= slot_data[sel];
            cnt          <= CNT_W'(MEM_LATENCY - 1);
            bus.bus_busy <= 1'b1;
            state        <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            if (cur_wr) begin
              mem[cur_addr] <= cur_data;
              if (grant) begin
                bus.flag_snoop0    <= 1'b1;
                bus.snoop_address0 <= cur_addr;
              end else begin
                bus.flag_snoop1    <= 1'b1;
                bus.snoop_address1 <= cur_addr;
              end
            end else begin
              bus.out_data_Mem <= mem[cur_addr];
            end
            if (grant) bus.finish1 <= 1'b1;
            else       bus.finish0 <= 1'b1;
            bus.bus_busy <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bus_arbiter_mem.sv
// Bench for bus_arbiter_mem: directed scenarios with literal expectations plus random traffic,
// all outputs compared every cycle against a timestamp-based transaction model.
module tb_bus_arbiter_mem;
  localparam int LAT = 2;

  logic CC_clk = 1'b0;
  logic rst    = 1'b1;
  always #5 CC_clk = ~CC_clk;

  bus_arbiter_mem_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  bus_arbiter_mem #(.MEM_LATENCY(LAT), .ADDR_W(8), .DATA_W(8)) dut (
    .CC_clk (CC_clk),
    .rst    (rst),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction model: pending slots, one in-flight op with a completion timestamp.
  bit         model_ok = 0;
  bit         m_pend [2];
  bit         m_wr   [2];
  logic [7:0] m_addr [2];
  logic [7:0] m_data [2];
  logic [7:0] m_mem  [256];
  bit         m_active, m_last, m_cur, m_cw;
  logic [7:0] m_ca, m_cd;
  int         m_done;
  bit         e_fin0, e_fin1, e_fl0, e_fl1, e_busy;
  logic [7:0] e_out, e_sa0, e_sa1;

  always @(posedge CC_clk) begin
    bit         op [2];
    bit         acc [2];
    bit         aw [2];
    logic [7:0] aa [2];
    logic [7:0] ad [2];
    bit         g;
    cyc++;
    acc = '{bus.bus_access0, bus.bus_access1};
    aw  = '{bus.write_opn0, bus.write_opn1};
    aa  = '{bus.addr0, bus.addr1};
    ad  = '{bus.wdata0, bus.wdata1};
    if (rst) begin
      m_pend = '{0, 0};
      m_active = 0; m_last = 1;
      e_fin0 = 0; e_fin1 = 0; e_fl0 = 0; e_fl1 = 0; e_busy = 0;
      e_out = 0; e_sa0 = 0; e_sa1 = 0;
      foreach (m_mem[i]) m_mem[i] = 8'h00;
      model_ok = 1;
    end else begin
      op = m_pend;
      e_fin0 = 0; e_fin1 = 0; e_fl0 = 0; e_fl1 = 0;
      if (m_active && cyc == m_done) begin
        if (m_cw) begin
          m_mem[m_ca] = m_cd;
          if (m_cur) begin e_fl0 = 1; e_sa0 = m_ca; end
          else       begin e_fl1 = 1; e_sa1 = m_ca; end
        end else begin
          e_out = m_mem[m_ca];
        end
        if (m_cur) e_fin1 = 1; else e_fin0 = 1;
        m_active = 0;
      end else if (!m_active && (op[0] || op[1])) begin
        g = (op[0] && op[1]) ? !m_last : !op[0];
        m_last = g; m_cur = g;
        m_cw = m_wr[g]; m_ca = m_addr[g]; m_cd = m_data[g];
        m_pend[g] = 0;
        m_done = cyc + LAT;
        m_active = 1;
      end
      for (int i = 0; i < 2; i++) begin
        if (acc[i] && !op[i]) begin
          m_pend[i] = 1; m_wr[i] = aw[i]; m_addr[i] = aa[i]; m_data[i] = ad[i];
        end
      end
    end
    e_busy = m_active;
  end

  always @(negedge CC_clk) begin
    if (model_ok) begin
      chk("finish0", bus.finish0, e_fin0);
      chk("finish1", bus.finish1, e_fin1);
      chk("flag_snoop0", bus.flag_snoop0, e_fl0);
      chk("flag_snoop1", bus.flag_snoop1, e_fl1);
      chk("bus_busy", bus.bus_busy, e_busy);
      chk("out_data_Mem", bus.out_data_Mem, e_out);
      if (e_fl0) chk("snoop_address0", bus.snoop_address0, e_sa0);
      if (e_fl1) chk("snoop_address1", bus.snoop_address1, e_sa1);
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge CC_clk);
    rst = 1'b0;
  endtask

  task automatic send(input bit v0, input bit w0, input logic [7:0] a0, input logic [7:0] d0,
                      input bit v1, input bit w1, input logic [7:0] a1, input logic [7:0] d1);
    bus.bus_access0 = v0; bus.write_opn0 = w0; bus.addr0 = a0; bus.wdata0 = d0;
    bus.bus_access1 = v1; bus.write_opn1 = w1; bus.addr1 = a1; bus.wdata1 = d1;
    @(negedge CC_clk);
    bus.bus_access0 = 1'b0;
    bus.bus_access1 = 1'b0;
  endtask

  task automatic wait_fin(input int id, output int n);
    n = 0;
    while (((id == 0) ? bus.finish0 : bus.finish1) !== 1'b1 && n < 50) begin
      @(negedge CC_clk);
      n++;
    end
    if (n >= 50) begin
      n_cmp++; n_err++;
      $display("FAIL wait_finish%0d: no finish within 50 cycles, expected one", id);
    end
  endtask

  int n;
  int order [6];
  int n_done, iss0, iss1, cnt1;
  logic [7:0] rd1;
  int exp_order [6] = '{0, 1, 0, 1, 0, 1};

  initial begin
    bus.bus_access0 = 0; bus.write_opn0 = 0; bus.addr0 = 0; bus.wdata0 = 0;
    bus.bus_access1 = 0; bus.write_opn1 = 0; bus.addr1 = 0; bus.wdata1 = 0;
    do_reset();
    chk("reset bus_busy", bus.bus_busy, 0);
    chk("reset out_data", bus.out_data_Mem, 8'h00);
    chk("reset finish0", bus.finish0, 0);

    // Single write then read
    send(1, 1, 8'h13, 8'h5A, 0, 0, 0, 0);
    wait_fin(0, n);
    chk("wr latency", n, 3);
    chk("wr flag_snoop1", bus.flag_snoop1, 1);
    chk("wr snoop_address1", bus.snoop_address1, 8'h13);
    chk("wr flag_snoop0", bus.flag_snoop0, 0);
    send(1, 0, 8'h13, 8'h00, 0, 0, 0, 0);
    wait_fin(0, n);
    chk("rd latency", n, 3);
    chk("rd data", bus.out_data_Mem, 8'h5A);

    // Simultaneous reads after reset
    do_reset();
    send(1, 0, 8'h00, 0, 1, 0, 8'h01, 0);
    wait_fin(0, n);
    chk("sim cc0 latency", n, 3);
    chk("sim cc0 data", bus.out_data_Mem, 8'h00);
    wait_fin(1, n);
    chk("sim cc1 extra latency", n, 3);
    chk("sim cc1 data", bus.out_data_Mem, 8'h00);

    // Round robin with both controllers saturating
    do_reset();
    bus.write_opn0 = 0; bus.write_opn1 = 0; bus.addr0 = 8'h05; bus.addr1 = 8'h06;
    bus.bus_access0 = 1; bus.bus_access1 = 1;
    iss0 = 1; iss1 = 1; n_done = 0;
    for (int k = 0; k < 100 && n_done < 6; k++) begin
      @(negedge CC_clk);
      bus.bus_access0 = 0; bus.bus_access1 = 0;
      if (bus.finish0 === 1'b1) begin
        order[n_done] = 0; n_done++;
        if (iss0 < 3) begin bus.bus_access0 = 1; iss0++; end
      end
      if (bus.finish1 === 1'b1 && n_done < 6) begin
        order[n_done] = 1; n_done++;
        if (iss1 < 3) begin bus.bus_access1 = 1; iss1++; end
      end
    end
    chk("rr count", n_done, 6);
    for (int k = 0; k < 6; k++) chk($sformatf("rr grant[%0d]", k), order[k], exp_order[k]);
    repeat (3) @(negedge CC_clk);

    // Read queued behind a write to the same address
    do_reset();
    send(0, 0, 0, 0, 1, 1, 8'h80, 8'hC3);
    @(negedge CC_clk);
    chk("q busy during write", bus.bus_busy, 1);
    send(1, 0, 8'h80, 0, 0, 0, 0, 0);
    wait_fin(1, n);
    chk("q flag_snoop0", bus.flag_snoop0, 1);
    chk("q snoop_address0", bus.snoop_address0, 8'h80);
    chk("q flag_snoop1", bus.flag_snoop1, 0);
    wait_fin(0, n);
    chk("q read wait", n, 3);
    chk("q read data", bus.out_data_Mem, 8'hC3);

    // Reset one cycle after grant
    do_reset();
    send(1, 1, 8'h22, 8'hFF, 0, 0, 0, 0);
    @(negedge CC_clk);
    chk("mid busy before rst", bus.bus_busy, 1);
    rst = 1'b1;
    @(negedge CC_clk);
    rst = 1'b0;
    chk("mid busy after rst", bus.bus_busy, 0);
    cnt1 = 0;
    repeat (6) begin
      @(negedge CC_clk);
      if (bus.finish0 === 1'b1 || bus.flag_snoop1 === 1'b1) cnt1++;
    end
    chk("mid no finish/snoop", cnt1, 0);
    send(1, 0, 8'h22, 0, 0, 0, 0, 0);
    wait_fin(0, n);
    chk("mid read data", bus.out_data_Mem, 8'h00);

    // Duplicate cc1 pulse while its request is still pending
    do_reset();
    send(1, 1, 8'h40, 8'h11, 0, 0, 0, 0);
    wait_fin(0, n);
    send(1, 1, 8'h41, 8'h22, 0, 0, 0, 0);
    wait_fin(0, n);
    send(1, 1, 8'h50, 8'h33, 0, 0, 0, 0);
    send(0, 0, 0, 0, 1, 0, 8'h40, 0);
    send(0, 0, 0, 0, 1, 0, 8'h41, 0);
    cnt1 = 0; rd1 = 8'hxx;
    repeat (15) begin
      @(negedge CC_clk);
      if (bus.finish1 === 1'b1) begin cnt1++; rd1 = bus.out_data_Mem; end
    end
    chk("dup finish1 count", cnt1, 1);
    chk("dup read data", rd1, 8'h11);

    // Random traffic, including occasional resets
    for (int k = 0; k < 1500; k++) begin
      bus.bus_access0 = ($urandom_range(0, 2) == 0);
      bus.write_opn0  = 1'($urandom_range(0, 1));
      bus.addr0       = 8'($urandom_range(0, 7));
      bus.wdata0      = 8'($urandom);
      bus.bus_access1 = ($urandom_range(0, 2) == 0);
      bus.write_opn1  = 1'($urandom_range(0, 1));
      bus.addr1       = 8'($urandom_range(0, 7));
      bus.wdata1      = 8'($urandom);
      rst             = ($urandom_range(0, 299) == 0);
      @(negedge CC_clk);
    end
    bus.bus_access0 = 0; bus.bus_access1 = 0; rst = 0;
    repeat (20) @(negedge CC_clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
